// File: rtl/find_my_best_pkg.sv
// Node-memory geometry shared by the neighbour-selection pipeline stages.
// Word/address widths, table depth and the neighbour-table address map.
package find_my_best_pkg;

  localparam int NODE_WORD_W  = 16;
  localparam int NODE_ADDR_W  = 11;
  localparam int NODE_MAX_NBR = 64;

  localparam logic [10:0] NODE_NBR_CNT_ADDR = 11'h68A;
  localparam logic [10:0] NODE_NBR_ID_BASE  = 11'h048;
  localparam logic [10:0] NODE_QVAL_BASE    = 11'h1C8;

  localparam logic [15:0] NO_NEIGHBOR_ID = 16'hFFFF;

endpackage

// File: rtl/find_my_best.sv
// Scans the neighbour table in node memory and publishes the entry with the
// highest Q-value (lowest index wins ties), then raises done_findMyBest.
module find_my_best
  import find_my_best_pkg::*;
#(
  parameter int                WORD_W       = NODE_WORD_W,
  parameter int                ADDR_W       = NODE_ADDR_W,
  parameter int                MAX_NBR      = NODE_MAX_NBR,
  parameter logic [ADDR_W-1:0] NBR_CNT_ADDR = ADDR_W'(NODE_NBR_CNT_ADDR),
  parameter logic [ADDR_W-1:0] NBR_ID_BASE  = ADDR_W'(NODE_NBR_ID_BASE),
  parameter logic [ADDR_W-1:0] QVAL_BASE    = ADDR_W'(NODE_QVAL_BASE)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic [WORD_W-1:0] mem_data_in,
  output logic [WORD_W-1:0] mybest,
  output logic [WORD_W-1:0] bestneighborID,
  output logic [WORD_W-1:0] besthop,
  output logic              done_findMyBest
);

  localparam int IDX_W = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_LD_CNT, S_RD_Q, S_LD_Q, S_RD_ID, S_LD_ID, S_DONE
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   cnt_r;
  logic [WORD_W-1:0]  q_r;
  logic [IDX_W-1:0]   clamp_cnt_s;
  logic [IDX_W-1:0]   idx_next_s;
  logic               better_s;

  function automatic logic [ADDR_W-1:0] entry_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

  assign wr_en       = 1'b0;
  assign mem_data_in = {WORD_W{1'b0}};

  // Count clamp, next index and the strictly-greater comparator.
  always_comb begin
    idx_next_s = idx_r + 7'd1;
    if (mem_data_out > WORD_W'(MAX_NBR)) begin
      clamp_cnt_s = IDX_W'(MAX_NBR);
    end else begin
      clamp_cnt_s = mem_data_out[IDX_W-1:0];
    end
    better_s = (q_r > mybest) || (idx_r == 7'd0);
  end

  // Scan FSM; each address is registered on entry to its RD_* state so the
  // synchronous read data is ready in the following LD_* state.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r         <= S_IDLE;
      address         <= {ADDR_W{1'b0}};
      mybest          <= {WORD_W{1'b0}};
      bestneighborID  <= NO_NEIGHBOR_ID;
      besthop         <= {WORD_W{1'b0}};
      done_findMyBest <= 1'b0;
      idx_r           <= 7'd0;
      cnt_r           <= 7'd0;
      q_r             <= {WORD_W{1'b0}};
    end else if (en) begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            address <= NBR_CNT_ADDR;
            state_r <= S_RD_CNT;
          end
        end
        S_RD_CNT: state_r <= S_LD_CNT;
        S_LD_CNT: begin
          cnt_r          <= clamp_cnt_s;
          idx_r          <= 7'd0;
          mybest         <= {WORD_W{1'b0}};
          bestneighborID <= NO_NEIGHBOR_ID;
          besthop        <= {WORD_W{1'b0}};
          if (clamp_cnt_s == 7'd0) begin
            state_r <= S_DONE;
          end else begin
            address <= entry_addr(QVAL_BASE, 7'd0);
            state_r <= S_RD_Q;
          end
        end
        S_RD_Q: state_r <= S_LD_Q;
        S_LD_Q: begin
          q_r     <= mem_data_out;
          address <= entry_addr(NBR_ID_BASE, idx_r);
          state_r <= S_RD_ID;
        end
        S_RD_ID: state_r <= S_LD_ID;
        S_LD_ID: begin
          if (better_s) begin
            mybest         <= q_r;
            bestneighborID <= mem_data_out;
            besthop        <= WORD_W'(idx_r);
          end
          idx_r <= idx_next_s;
          if (idx_next_s == cnt_r) begin
            state_r <= S_DONE;
          end else begin
            address <= entry_addr(QVAL_BASE, idx_next_s);
            state_r <= S_RD_Q;
          end
        end
        S_DONE: begin
          if (start) begin
            done_findMyBest <= 1'b0;
            address         <= NBR_CNT_ADDR;
            state_r         <= S_RD_CNT;
          end else begin
            done_findMyBest <= 1'b1;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_my_best.sv
// Self-checking bench for find_my_best: directed scenarios plus random tables
// compared against a plain-loop reference model of the neighbour scan.
module tb_find_my_best;
  import find_my_best_pkg::*;

  localparam int CNT_A = 11'h68A;
  localparam int ID_B  = 11'h048;
  localparam int Q_B   = 11'h1C8;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_data_out = 16'd0;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mybest, bestneighborID, besthop;
  logic        done_findMyBest;

  logic [15:0] mem [0:2047];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        chk_on   = 1'b0;
  logic [15:0] exp_best, exp_id, exp_hop;
  int          exp_cnt;

  find_my_best dut (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .mem_data_out(mem_data_out), .address(address), .wr_en(wr_en),
    .mem_data_in(mem_data_in), .mybest(mybest), .bestneighborID(bestneighborID),
    .besthop(besthop), .done_findMyBest(done_findMyBest)
  );

  always #5 clock = ~clock;

  // Synchronous-read node memory
  always @(posedge clock) mem_data_out <= mem[address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit addr_ok(input logic [10:0] a);
    if (int'(a) == 0 || int'(a) == CNT_A) return 1'b1;
    for (int i = 0; i < 64; i++)
      if (int'(a) == Q_B + 2*i || int'(a) == ID_B + 2*i) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: clamp the count, walk the table, keep the first strict maximum.
  task automatic model(output logic [15:0] b, output logic [15:0] id,
                       output logic [15:0] hop, output int cnt);
    cnt = int'(mem[CNT_A]);
    if (cnt > 64) cnt = 64;
    b = 16'd0; id = 16'hFFFF; hop = 16'd0;
    for (int i = 0; i < cnt; i++) begin
      if (i == 0 || mem[Q_B + 2*i] > b) begin
        b = mem[Q_B + 2*i]; id = mem[ID_B + 2*i]; hop = 16'(i);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
  endtask

  task automatic set_entry(input int i, input logic [15:0] q, input logic [15:0] id);
    mem[Q_B + 2*i]  = q;
    mem[ID_B + 2*i] = id;
  endtask

  task automatic load_s1();
    clear_mem();
    mem[CNT_A] = 16'd3;
    set_entry(0, 16'h0100, 16'd7);
    set_entry(1, 16'h1140, 16'd9);
    set_entry(2, 16'h0800, 16'd12);
  endtask

  // Pulse start, wait for done (bounded) and check latency against the model.
  task automatic run_scan(input int drop_at, input bit rand_en, output int cycles);
    int lows;
    model(exp_best, exp_id, exp_hop, exp_cnt);
    chk_on = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk_on = 1'b1;
    cycles = 0;
    lows   = 0;
    while (!done_findMyBest && cycles < 2000) begin
      if (rand_en) en = ($urandom_range(0, 3) != 0);
      else         en = !(drop_at >= 0 && cycles >= drop_at && cycles < drop_at + 5);
      if (!en) lows++;
      tick();
      cycles++;
    end
    en = 1'b1;
    check("done_seen", {31'd0, done_findMyBest}, 32'd1);
    check("latency", cycles, 3 + 4*exp_cnt + lows);
    tick();
  endtask

  initial begin
    int cyc;
    logic [15:0] b, id, hop;
    int cnt;

    // Per-cycle monitor: constant write port, legal addresses, results on done.
    fork
      forever begin
        @(negedge clock);
        if (!rst) begin
          check("wr_en", {31'd0, wr_en}, 32'd0);
          check("mem_data_in", {16'd0, mem_data_in}, 32'd0);
          check("addr_legal", {31'd0, addr_ok(address)}, 32'd1);
          if (chk_on && done_findMyBest) begin
            check("mybest", {16'd0, mybest}, {16'd0, exp_best});
            check("bestneighborID", {16'd0, bestneighborID}, {16'd0, exp_id});
            check("besthop", {16'd0, besthop}, {16'd0, exp_hop});
          end
        end
      end
    join_none

    clear_mem();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_address", {21'd0, address}, 32'd0);
    check("rst_mybest", {16'd0, mybest}, 32'd0);
    check("rst_id", {16'd0, bestneighborID}, 32'h0000FFFF);
    check("rst_hop", {16'd0, besthop}, 32'd0);
    check("rst_done", {31'd0, done_findMyBest}, 32'd0);
    rst = 1'b0;
    tick();

    // Scenario 1: basic maximum
    load_s1();
    model(b, id, hop, cnt);
    check("model_s1_best", {16'd0, b}, 32'h1140);
    check("model_s1_id", {16'd0, id}, 32'd9);
    check("model_s1_hop", {16'd0, hop}, 32'd1);
    run_scan(-1, 1'b0, cyc);
    check("s1_latency", cyc, 15);

    // Scenario 2: empty table
    clear_mem();
    run_scan(-1, 1'b0, cyc);
    check("s2_latency", cyc, 3);
    check("s2_id", {16'd0, bestneighborID}, 32'h0000FFFF);

    // Scenario 3: tie keeps the lower index
    clear_mem();
    mem[CNT_A] = 16'd2;
    set_entry(0, 16'h0500, 16'd4);
    set_entry(1, 16'h0500, 16'd5);
    model(b, id, hop, cnt);
    check("model_tie_id", {16'd0, id}, 32'd4);
    run_scan(-1, 1'b0, cyc);
    check("tie_hop", {16'd0, besthop}, 32'd0);

    // Scenario 4: count clamp to 64
    clear_mem();
    mem[CNT_A] = 16'd100;
    for (int i = 0; i < 100; i++) set_entry(i, (i >= 63) ? 16'hFFFF : 16'd1, 16'(100 + i));
    model(b, id, hop, cnt);
    check("model_clamp_hop", {16'd0, hop}, 32'd63);
    run_scan(-1, 1'b0, cyc);
    check("clamp_latency", cyc, 259);
    check("clamp_hop", {16'd0, besthop}, 32'd63);

    // Scenario 5: en dropped for 5 cycles mid-scan
    load_s1();
    run_scan(6, 1'b0, cyc);
    check("en_drop_latency", cyc, 20);

    // Scenario 6: rst during LD_Q of entry 1, then a normal rescan
    load_s1();
    chk_on = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_done", {31'd0, done_findMyBest}, 32'd0);
    check("midrst_mybest", {16'd0, mybest}, 32'd0);
    check("midrst_id", {16'd0, bestneighborID}, 32'h0000FFFF);
    check("midrst_address", {21'd0, address}, 32'd0);
    rst = 1'b0;
    tick();
    run_scan(-1, 1'b0, cyc);
    check("post_rst_best", {16'd0, mybest}, 32'h1140);

    // Random tables, with random en gaps on odd iterations
    for (int t = 0; t < 10; t++) begin
      clear_mem();
      mem[CNT_A] = (t == 3) ? 16'd65 : 16'($urandom_range(0, 70));
      for (int i = 0; i < 100; i++)
        set_entry(i, ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
                  16'($urandom));
      run_scan(-1, t[0], cyc);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
